// File: rtl/iic_cmd_seq.sv
// Command sequencer in front of iic_master: FIFO-buffers register transactions, issues them one at a time,
// and returns read data / error status. Define IIC_CMD_SEQ_RETRY_EN to retry a failed transaction once.
module iic_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_wr_i,
    input  logic [6:0] cmd_slv_i,
    input  logic [7:0] cmd_reg_i,
    input  logic [7:0] cmd_data_i,
    output logic [6:0] Slv_Addr_o,
    output logic [7:0] Reg_Addr_o,
    output logic [7:0] Data_o,
    output logic       wr_o,
    output logic       send_o,
    input  logic       iic_done_i,
    input  logic       iic_nack_i,
    input  logic [7:0] IIC_Read_Data_i,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output logic [7:0] rd_data_o,
    output logic       rd_err_o,
    output logic       busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESULT
    } state_t;

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [6:0]    slv_q, slv_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;
`ifdef IIC_CMD_SEQ_RETRY_EN
    logic          retry_q, retry_d;
`endif

    assign cmd_ready_o = (count_q != FULL_CNT);
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);

    // FIFO storage has no reset so it can map onto RAM; only pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_wr_i, cmd_slv_i, cmd_reg_i, cmd_data_i};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slv_d     = slv_q;
        reg_d     = reg_q;
        data_d    = data_q;
        wr_d      = wr_q;
        timer_d   = timer_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
`ifdef IIC_CMD_SEQ_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {wr_d, slv_d, reg_d, data_d} = mem_q[rd_ptr_q];
                    state_d = S_LOAD;
`ifdef IIC_CMD_SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done pulse takes priority over a coincident timeout.
                if (iic_done_i && !iic_nack_i) begin
                    if (wr_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_RESULT;
                        rd_data_d = IIC_Read_Data_i;
                        rd_err_d  = 1'b0;
                    end
                end else if (iic_done_i || timer_q == TMO_LAST) begin
`ifdef IIC_CMD_SEQ_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d   = S_RESULT;
                        rd_data_d = 8'h00;
                        rd_err_d  = 1'b1;
                    end
`else
                    state_d   = S_RESULT;
                    rd_data_d = 8'h00;
                    rd_err_d  = 1'b1;
`endif
                end
            end
            S_RESULT: begin
                if (rd_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            slv_q     <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            timer_q   <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
`ifdef IIC_CMD_SEQ_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            slv_q     <= slv_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            timer_q   <= timer_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
`ifdef IIC_CMD_SEQ_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign Slv_Addr_o = slv_q;
    assign Reg_Addr_o = reg_q;
    assign Data_o     = data_q;
    assign wr_o       = wr_q;
    assign send_o     = (state_q == S_WAIT);
    assign rd_valid_o = (state_q == S_RESULT);
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;
    assign busy_o     = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_iic_cmd_seq.sv
// Self-checking bench for iic_cmd_seq: scenario tasks with a result scoreboard and an issue-order queue.
module tb_iic_cmd_seq;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_wr_i = 1'b0;
    logic [6:0] cmd_slv_i = '0;
    logic [7:0] cmd_reg_i = '0;
    logic [7:0] cmd_data_i = '0;
    logic [6:0] Slv_Addr_o;
    logic [7:0] Reg_Addr_o;
    logic [7:0] Data_o;
    logic       wr_o;
    logic       send_o;
    logic       iic_done_i = 1'b0;
    logic       iic_nack_i = 1'b0;
    logic [7:0] IIC_Read_Data_i = '0;
    logic       rd_valid_o;
    logic       rd_ready_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_err_o;
    logic       busy_o;

    iic_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_slv_i(cmd_slv_i), .cmd_reg_i(cmd_reg_i), .cmd_data_i(cmd_data_i),
        .Slv_Addr_o(Slv_Addr_o), .Reg_Addr_o(Reg_Addr_o), .Data_o(Data_o), .wr_o(wr_o),
        .send_o(send_o), .iic_done_i(iic_done_i), .iic_nack_i(iic_nack_i),
        .IIC_Read_Data_i(IIC_Read_Data_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o), .rd_err_o(rd_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] data; logic err;} res_t;
    typedef struct packed {logic wr; logic [6:0] slv; logic [7:0] rg; logic [7:0] d;} cmd_t;

    res_t exp_q[$];
    cmd_t cmd_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic push_cmd(input cmd_t c);
        @(negedge clk);
        cmd_valid_i = 1'b1;
        {cmd_wr_i, cmd_slv_i, cmd_reg_i, cmd_data_i} = c;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL push_ready: cmd_ready_o=%b expected 1", cmd_ready_o);
        end
        cmd_q.push_back(c);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_send(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (send_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_send: send_o never rose within 300 cycles, expected 1", name);
        end
    endtask

    task automatic pulse_done(input logic nack, input logic [7:0] rdata);
        @(negedge clk);
        iic_done_i = 1'b1;
        iic_nack_i = nack;
        IIC_Read_Data_i = rdata;
        @(negedge clk);
        iic_done_i = 1'b0;
        iic_nack_i = 1'b0;
    endtask

    // Scoreboard pop: wait for a result, compare against the oldest expectation, then handshake.
    task automatic consume_result(input string name);
        bit   ok = 1'b0;
        res_t e;
        for (int i = 0; i < 400; i++) begin
            if (rd_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_result: rd_valid_o=%b pending=%0d, expected a result", name, rd_valid_o, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if ({rd_data_o, rd_err_o} !== {e.data, e.err}) begin
                n_fail++;
                $display("FAIL %s_data: got data=%h err=%b expected data=%h err=%b",
                         name, rd_data_o, rd_err_o, e.data, e.err);
            end
            rd_ready_i = 1'b1;
            @(negedge clk);
            rd_ready_i = 1'b0;
            n_checks++;
            if (rd_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_clear: rd_valid_o=%b expected 0 after handshake", name, rd_valid_o);
            end
        end
        $display("result %s checked", name);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready_o, send_o, busy_o, rd_valid_o, rd_err_o, wr_o} !== 6'b100000 ||
            {Slv_Addr_o, Reg_Addr_o, Data_o, rd_data_o} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b send=%b busy=%b valid=%b slv=%h reg=%h data=%h rd=%h expected ready=1 rest 0",
                     cmd_ready_o, send_o, busy_o, rd_valid_o, Slv_Addr_o, Reg_Addr_o, Data_o, rd_data_o);
        end
        rst_i = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_write();
        cmd_t c;
        push_cmd({1'b1, 7'h4B, 8'h36, 8'hC2});
        @(negedge clk);
        n_checks++;
        if (send_o !== 1'b0) begin
            n_fail++; $display("FAIL write_n0: send_o=%b expected 0", send_o);
        end
        @(negedge clk);
        c = cmd_q.pop_front();
        n_checks++;
        if (send_o !== 1'b0 || {wr_o, Slv_Addr_o, Reg_Addr_o, Data_o} !== c) begin
            n_fail++;
            $display("FAIL write_load: send=%b outs=%h expected send=0 outs=%h",
                     send_o, {wr_o, Slv_Addr_o, Reg_Addr_o, Data_o}, c);
        end
        @(negedge clk);
        n_checks++;
        if (send_o !== 1'b1) begin
            n_fail++; $display("FAIL write_send: send_o=%b expected 1 at N+2", send_o);
        end
        repeat (39) @(negedge clk);
        pulse_done(1'b0, 8'h00);
        n_checks++;
        if (send_o !== 1'b0 || rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL write_done: send=%b valid=%b expected 0 0", send_o, rd_valid_o);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL write_idle: valid=%b busy=%b expected 0 0", rd_valid_o, busy_o);
        end
        $display("write 4B/36/C2 checked");
    endtask

    task automatic test_read();
        cmd_t c;
        bit   held = 1'b1;
        push_cmd({1'b0, 7'h4B, 8'h36, 8'h00});
        exp_q.push_back({8'hA5, 1'b0});
        wait_send("read");
        c = cmd_q.pop_front();
        n_checks++;
        if ({wr_o, Slv_Addr_o, Reg_Addr_o} !== {c.wr, c.slv, c.rg}) begin
            n_fail++; $display("FAIL read_issue: wr=%b slv=%h reg=%h expected 0 4b 36", wr_o, Slv_Addr_o, Reg_Addr_o);
        end
        repeat (10) @(negedge clk);
        pulse_done(1'b0, 8'hA5);
        n_checks++;
        if (send_o !== 1'b0 || rd_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL read_edge: send=%b valid=%b expected 0 1", send_o, rd_valid_o);
        end
        IIC_Read_Data_i = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) held = 1'b0;
        end
        n_checks++;
        if (!held) begin
            n_fail++; $display("FAIL read_hold: valid=%b data=%h expected held 1 a5", rd_valid_o, rd_data_o);
        end
        consume_result("read");
    endtask

    task automatic test_fill();
        cmd_t c;
        int   acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            c = {1'b1, 7'(8'h10 + i), 8'(i), 8'(8'hF0 ^ i)};
            cmd_valid_i = 1'b1;
            {cmd_wr_i, cmd_slv_i, cmd_reg_i, cmd_data_i} = c;
            if (cmd_ready_o === 1'b1) begin
                cmd_q.push_back(c);
                acc++;
            end
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        n_checks++;
        if (acc != DEPTH + 1 || cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL fill_count: accepted=%0d ready=%b expected %0d 0", acc, cmd_ready_o, DEPTH + 1);
        end
        for (int k = 0; k < acc; k++) begin
            wait_send("fill");
            c = cmd_q.pop_front();
            n_checks++;
            if ({wr_o, Slv_Addr_o, Reg_Addr_o, Data_o} !== c) begin
                n_fail++; $display("FAIL fill_order%0d: outs=%h expected %h", k, {wr_o, Slv_Addr_o, Reg_Addr_o, Data_o}, c);
            end
            pulse_done(1'b0, 8'h00);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL fill_drain: busy=%b ready=%b expected 0 1", busy_o, cmd_ready_o);
        end
        $display("fill %0d commands checked", acc);
    endtask

    task automatic test_timeout();
        int cnt;
        int pulses = 1;
`ifdef IIC_CMD_SEQ_RETRY_EN
        pulses = 2;
`endif
        push_cmd({1'b0, 7'h21, 8'h05, 8'h00});
        exp_q.push_back({8'h00, 1'b1});
        void'(cmd_q.pop_front());
        for (int p = 0; p < pulses; p++) begin
            wait_send("timeout");
            cnt = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (send_o !== 1'b1) break;
                cnt++;
            end
            n_checks++;
            if (cnt != TIMEOUT) begin
                n_fail++; $display("FAIL timeout_len%0d: send high %0d cycles expected %0d", p, cnt, TIMEOUT);
            end
        end
        consume_result("timeout");
    endtask

    task automatic test_nack();
        push_cmd({1'b1, 7'h4B, 8'h36, 8'h11});
        exp_q.push_back({8'h00, 1'b1});
        void'(cmd_q.pop_front());
        wait_send("nack");
        pulse_done(1'b1, 8'h77);
`ifdef IIC_CMD_SEQ_RETRY_EN
        n_checks++;
        if (rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL nack_retry: valid=%b expected 0 after first NACK", rd_valid_o);
        end
        wait_send("nack_retry");
        pulse_done(1'b1, 8'h77);
`endif
        consume_result("nack");
    endtask

    task automatic test_done_timeout();
        push_cmd({1'b0, 7'h33, 8'h44, 8'h00});
        exp_q.push_back({8'h3C, 1'b0});
        void'(cmd_q.pop_front());
        wait_send("tie");
        repeat (TIMEOUT - 1) @(negedge clk);
        n_checks++;
        if (send_o !== 1'b1) begin
            n_fail++; $display("FAIL tie_early: send=%b expected 1 in last WAIT cycle", send_o);
        end
        iic_done_i = 1'b1;
        IIC_Read_Data_i = 8'h3C;
        @(negedge clk);
        iic_done_i = 1'b0;
        consume_result("done_vs_timeout");
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        push_cmd({1'b1, 7'h01, 8'h02, 8'h03});
        push_cmd({1'b1, 7'h04, 8'h05, 8'h06});
        void'(cmd_q.pop_front());
        void'(cmd_q.pop_front());
        wait_send("b2b");
        pulse_done(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (send_o === 1'b1) break;
            gap++;
            @(negedge clk);
        end
        n_checks++;
        if (gap != 2 || Slv_Addr_o !== 7'h04) begin
            n_fail++; $display("FAIL b2b_gap: low cycles=%0d slv=%h expected 2 04", gap, Slv_Addr_o);
        end
        pulse_done(1'b0, 8'h00);
        $display("back-to-back gap %0d checked", gap);
    endtask

    task automatic test_done_ignored();
        repeat (2) @(negedge clk);
        pulse_done(1'b1, 8'hEE);
        @(negedge clk);
        n_checks++;
        if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || send_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_done: valid=%b busy=%b send=%b expected 0 0 0", rd_valid_o, busy_o, send_o);
        end
        $display("idle done pulse checked");
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd({1'b1, 7'(7'h50 + i), 8'h00, 8'h00});
        wait_send("rst_mid");
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (send_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: send=%b busy=%b ready=%b expected 0 0 1", send_o, busy_o, cmd_ready_o);
        end
        rst_i = 1'b0;
        cmd_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++; $display("FAIL rst_stale: send=%b busy=%b expected no stale issue", send_o, busy_o);
        end
        $display("mid-transaction reset checked");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fill();
        test_timeout();
        test_nack();
        test_done_timeout();
        test_back_to_back();
        test_done_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
